pc_fetch_unit: RTL and testbench

//  Program-counter register and IF stage of the RV32IM pipeline. Consumes BRANCH_SEL/B_PC from the branch/jump

---
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and IF stage: drives instruction-memory address and IF/ID register, handles stalls, wait states, redirects.
// Optional misaligned-redirect trap (TRAP/BAD_ADDR) enabled by defining BR_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
`ifdef BR_MISALIGN_TRAP_EN
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
`endif
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_SEL,
  input  logic [31:0] B_PC,
  input  logic        STALL,
  input  logic        IMEM_BUSY,
  input  logic [31:0] IMEM_INSTR,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC_ID,
  output logic [31:0] PC4_ID,
  output logic [31:0] INSTR_ID,
  output logic        VALID_ID
`ifdef BR_MISALIGN_TRAP_EN
  ,
  output logic        TRAP,
  output logic [31:0] BAD_ADDR
`endif
);

  typedef enum logic {FETCH, REDIRECT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] target, target_n;
  logic [31:0] pc_id_n, pc4_id_n, instr_id_n;
  logic        valid_id_n;
  logic [31:0] br_tgt;
  logic        trap_n;
  logic [31:0] bad_addr_n;
  logic [31:0] bad_addr_q;

  assign IMEM_ADDR = pc;

`ifdef BR_MISALIGN_TRAP_EN
  logic br_mis;
  assign br_mis = |B_PC[1:0];
  assign br_tgt = br_mis ? TRAP_VECTOR : B_PC;
`else
  assign br_tgt = {B_PC[31:2], 2'b00};
`endif

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    target_n   = target;
    pc_id_n    = PC_ID;
    pc4_id_n   = PC4_ID;
    instr_id_n = INSTR_ID;
    valid_id_n = VALID_ID;
    trap_n     = 1'b0;
    bad_addr_n = bad_addr_q;

    if (BRANCH_SEL) begin
`ifdef BR_MISALIGN_TRAP_EN
      if (br_mis) begin
        trap_n     = 1'b1;
        bad_addr_n = B_PC;
      end
`endif
    end

    case (state)
      FETCH: begin
        if (BRANCH_SEL) begin
          instr_id_n = NOP_INSTR;
          valid_id_n = 1'b0;
          if (IMEM_BUSY) begin
            target_n = br_tgt;
            state_n  = REDIRECT;
          end else begin
            pc_n = br_tgt;
          end
        end else if (STALL) begin
          // hold everything
        end else if (IMEM_BUSY) begin
          instr_id_n = NOP_INSTR;
          valid_id_n = 1'b0;
        end else begin
          pc_id_n    = pc;
          pc4_id_n   = pc + 32'd4;
          instr_id_n = IMEM_INSTR;
          valid_id_n = 1'b1;
          pc_n       = pc + 32'd4;
        end
      end
      REDIRECT: begin
        // The word returned for the stale address is dropped; IF/ID stays a bubble.
        instr_id_n = NOP_INSTR;
        valid_id_n = 1'b0;
        if (BRANCH_SEL) begin
          target_n = br_tgt;
          if (!IMEM_BUSY) begin
            pc_n    = br_tgt;
            state_n = FETCH;
          end
        end else if (!IMEM_BUSY) begin
          pc_n    = target;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      target     <= 32'd0;
      PC_ID      <= 32'd0;
      PC4_ID     <= 32'd0;
      INSTR_ID   <= NOP_INSTR;
      VALID_ID   <= 1'b0;
      bad_addr_q <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      target     <= target_n;
      PC_ID      <= pc_id_n;
      PC4_ID     <= pc4_id_n;
      INSTR_ID   <= instr_id_n;
      VALID_ID   <= valid_id_n;
      bad_addr_q <= bad_addr_n;
    end
  end

`ifdef BR_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RESET) TRAP <= 1'b0;
    else       TRAP <= trap_n;
  end
  assign BAD_ADDR = bad_addr_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, trap_n, bad_addr_n[0]};
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit against a cycle-level behavioural model.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] TRAPV = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RESET, BRANCH_SEL, STALL, IMEM_BUSY;
  logic [31:0] B_PC, IMEM_INSTR;
  logic [31:0] IMEM_ADDR, PC_ID, PC4_ID, INSTR_ID;
  logic        VALID_ID;
`ifdef BR_MISALIGN_TRAP_EN
  logic        TRAP;
  logic [31:0] BAD_ADDR;
`endif

  always #5 CLK = ~CLK;

  pc_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .BRANCH_SEL(BRANCH_SEL), .B_PC(B_PC), .STALL(STALL),
    .IMEM_BUSY(IMEM_BUSY), .IMEM_INSTR(IMEM_INSTR), .IMEM_ADDR(IMEM_ADDR),
    .PC_ID(PC_ID), .PC4_ID(PC4_ID), .INSTR_ID(INSTR_ID), .VALID_ID(VALID_ID)
`ifdef BR_MISALIGN_TRAP_EN
    , .TRAP(TRAP), .BAD_ADDR(BAD_ADDR)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'h0} ^ a ^ 32'h5A5A_0033;
  endfunction

  assign IMEM_INSTR = IMEM_BUSY ? 32'hDEAD_BEEF : mem_word(IMEM_ADDR);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: fetch pointer, optional pending redirect target, IF/ID contents.
  logic [31:0] m_pc, m_tgt, m_pc_id, m_pc4, m_instr, m_bad;
  logic        m_pending, m_valid, m_trap;

  task automatic model_edge();
    logic [31:0] dest;
    logic [31:0] fetched;
    fetched = mem_word(m_pc);
    m_trap  = 1'b0;
    if (RESET) begin
      m_pc = 32'h0; m_tgt = 0; m_pending = 0; m_pc_id = 0; m_pc4 = 0;
      m_instr = NOP; m_valid = 0; m_bad = 0;
      return;
    end
    dest = B_PC & 32'hFFFF_FFFC;
`ifdef BR_MISALIGN_TRAP_EN
    if (BRANCH_SEL && B_PC[1:0] != 2'b00) begin
      dest = TRAPV; m_trap = 1'b1; m_bad = B_PC;
    end
`endif
    if (m_pending) begin
      m_instr = NOP; m_valid = 0;
      if (BRANCH_SEL) m_tgt = dest;
      if (!IMEM_BUSY) begin m_pc = m_tgt; m_pending = 0; end
    end else if (BRANCH_SEL) begin
      m_instr = NOP; m_valid = 0;
      if (IMEM_BUSY) begin m_tgt = dest; m_pending = 1; end
      else m_pc = dest;
    end else if (STALL) begin
      // frozen
    end else if (IMEM_BUSY) begin
      m_instr = NOP; m_valid = 0;
    end else begin
      m_pc_id = m_pc; m_pc4 = m_pc + 32'd4; m_instr = fetched; m_valid = 1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_addr"},  IMEM_ADDR, m_pc);
    check({tag, "_pcid"},  PC_ID,     m_pc_id);
    check({tag, "_pc4"},   PC4_ID,    m_pc4);
    check({tag, "_instr"}, INSTR_ID,  m_instr);
    check({tag, "_valid"}, {31'd0, VALID_ID}, {31'd0, m_valid});
`ifdef BR_MISALIGN_TRAP_EN
    check({tag, "_trap"},  {31'd0, TRAP}, {31'd0, m_trap});
    check({tag, "_bad"},   BAD_ADDR, m_bad);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic br, input logic [31:0] bpc,
                       input logic st, input logic busy);
    RESET = r; BRANCH_SEL = br; B_PC = bpc; STALL = st; IMEM_BUSY = busy;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    m_pc = 0; m_tgt = 0; m_pending = 0; m_pc_id = 0; m_pc4 = 0;
    m_instr = NOP; m_valid = 0; m_trap = 0; m_bad = 0;

    // T1: reset then sequential fetch
    step("t1_rst"); step("t1_rst");
    check("t1_rst_instr", INSTR_ID, NOP);
    drive(0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step("t1_seq");
      check("t1_addr_seq", IMEM_ADDR, 32'(4 * k));
      check("t1_pcid_lag", PC_ID, 32'(4 * (k - 1)));
    end

    // T2: taken branch at PC=0x10
    drive(0, 1, 32'h40, 0, 0);
    step("t2_br");
    check("t2_addr", IMEM_ADDR, 32'h40);
    check("t2_flush", INSTR_ID, NOP);
    drive(0, 0, 0, 0, 0);
    step("t2_next");
    check("t2_pcid", PC_ID, 32'h40);

    // T3: stall freezes, branch overrides stall
    drive(0, 0, 0, 1, 0);
    repeat (3) step("t3_stall");
    drive(0, 1, 32'h80, 1, 0);
    step("t3_br");
    check("t3_addr", IMEM_ADDR, 32'h80);

    // T4: redirect while memory busy, newest target wins
    drive(0, 1, 32'h200, 0, 1); step("t4_b1");
    drive(0, 1, 32'h300, 0, 1); step("t4_b2");
    drive(0, 0, 0, 0, 1); step("t4_w"); step("t4_w");
    drive(0, 0, 0, 0, 0); step("t4_go");
    check("t4_addr", IMEM_ADDR, 32'h300);
    check("t4_valid", {31'd0, VALID_ID}, 32'd0);

    // T5: address wrap
    drive(0, 1, 32'hFFFF_FFFC, 0, 0); step("t5_br");
    drive(0, 0, 0, 0, 0); step("t5_adv");
    check("t5_pcid", PC_ID, 32'hFFFF_FFFC);
    check("t5_pc4", PC4_ID, 32'h0);
    check("t5_addr", IMEM_ADDR, 32'h0);

    // T6: misaligned target
    drive(0, 1, 32'h42, 0, 0); step("t6_br");
`ifdef BR_MISALIGN_TRAP_EN
    check("t6_addr", IMEM_ADDR, TRAPV);
    check("t6_trap", {31'd0, TRAP}, 32'd1);
    check("t6_bad", BAD_ADDR, 32'h42);
    drive(0, 0, 0, 0, 0); step("t6_after");
    check("t6_trap_pulse", {31'd0, TRAP}, 32'd0);
`else
    check("t6_addr", IMEM_ADDR, 32'h40);
    drive(0, 0, 0, 0, 0); step("t6_after");
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12, b,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
